// File: rtl/aes128_decrypt_seq.sv
// Iterative AES-128 decryptor: ten forward key-schedule cycles to reach rk10,
// then ten inverse rounds that unwind the key schedule in place.
module aes128_decrypt_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;

  state_e       fsm_q;
  logic [3:0]   cnt_q;
  logic [127:0] key_q;
  logic [127:0] state_q;
  logic         in_ready_q;
  logic         out_valid_q;

  logic [127:0] key_fwd_d;
  logic [127:0] key_inv_d;
  logic [127:0] round_base_d;
  logic [127:0] round_mix_d;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(11'd255 - 11'(x)) * 11'd8 +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[(11'd255 - 11'(x)) * 11'd8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] a, b, c, d;
    a = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    b = k[95:64] ^ a;
    c = k[63:32] ^ b;
    d = k[31:0] ^ c;
    return {a, b, c, d};
  endfunction

  // Undo one schedule step: recover the last three words first, then the
  // first word needs the already-recovered fourth word.
  function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] a, b, c, d;
    d = k[31:0] ^ k[63:32];
    c = k[63:32] ^ k[95:64];
    b = k[95:64] ^ k[127:96];
    a = k[127:96] ^ sub_rot_word(d) ^ {rc, 24'h0};
    return {a, b, c, d};
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = inv_sbox(s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a  [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    logic [7:0]   x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127 - 8 * (r + 4 * c) -: 8];
        x2    = xt(a[r]);
        x4    = xt(x2);
        x8    = xt(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
      end
    end
    return o;
  endfunction

  always_comb begin
    key_fwd_d    = key_step_fwd(key_q, rcon(cnt_q));
    key_inv_d    = key_step_inv(key_q, rcon(cnt_q + 4'd1));
    round_base_d = inv_shift_sub(state_q) ^ key_inv_d;
    round_mix_d  = inv_mix_columns(round_base_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      cnt_q       <= 4'd0;
      key_q       <= '0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= ciphertext;
            key_q      <= key;
            cnt_q      <= 4'd1;
            in_ready_q <= 1'b0;
            fsm_q      <= KEYEXP;
          end
        end
        KEYEXP: begin
          key_q <= key_fwd_d;
          if (cnt_q == 4'd10) begin
            state_q <= state_q ^ key_fwd_d;
            cnt_q   <= 4'd9;
            fsm_q   <= ROUND;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ROUND: begin
          key_q <= key_inv_d;
          if (cnt_q == 4'd0) begin
            state_q     <= round_base_d;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            state_q <= round_mix_d;
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign plaintext = state_q;

endmodule

// File: tb/tb_aes128_decrypt_seq.sv
// Directed and loopback bench for aes128_decrypt_seq; the reference encryptor
// builds its S-box from GF(2^8) inverses rather than a copied table.
module tb_aes128_decrypt_seq;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  int checks;
  int errors;
  logic [7:0] sboxM [256];

  aes128_decrypt_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sboxM[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] encModel(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] rk [11];
    logic [127:0] s, t;
    logic [31:0]  w, n0, n1, n2, n3;
    logic [7:0]   rc;
    logic [7:0]   a [4];
    rk[0] = k;
    rc = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      w  = rk[i-1][31:0];
      n0 = rk[i-1][127:96] ^ {sboxM[w[23:16]], sboxM[w[15:8]], sboxM[w[7:0]], sboxM[w[31:24]]} ^ {rc, 24'h0};
      n1 = rk[i-1][95:64] ^ n0;
      n2 = rk[i-1][63:32] ^ n1;
      n3 = rk[i-1][31:0] ^ n2;
      rk[i] = {n0, n1, n2, n3};
      rc = gfMul(rc, 8'h02);
    end
    s = p ^ rk[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[127 - 8 * i -: 8] = sboxM[s[127 - 8 * i -: 8]];
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[127 - 8 * (r + 4 * c) -: 8];
          for (int r = 0; r < 4; r++)
            s[127 - 8 * (r + 4 * c) -: 8] = gfMul(a[r], 8'h02) ^ gfMul(a[(r + 1) % 4], 8'h03)
                                          ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
        end
      end
      s = s ^ rk[rnd];
    end
    return s;
  endfunction

  // Called on a falling edge with the DUT idle; returns on the falling edge after acceptance.
  task automatic startJob(input logic [127:0] ct, input logic [127:0] k);
    ciphertext = ct;
    key        = k;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (plaintext !== 128'h0) begin errors++; $display("[TB] FAIL reset_plaintext: got %h want 0", plaintext); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_vector(input string name, input logic [127:0] ct, input logic [127:0] k,
                             input logic [127:0] pt);
    int lat;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s_ready: got %b want 1", name, in_ready); end
    startJob(ct, k);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy: got %b want 0", name, in_ready); end
    waitResult(lat);
    checks++; if (lat !== 20) begin errors++; $display("[TB] FAIL %s_latency: got %0d want 20", name, lat); end
    checks++; if (plaintext !== pt) begin errors++; $display("[TB] FAIL %s_plaintext: got %h want %h", name, plaintext, pt); end
    releaseResult();
  endtask

  task automatic test_hold();
    int lat;
    startJob(Z_CT, 128'h0);
    waitResult(lat);
    checks++; if (plaintext !== 128'h0) begin errors++; $display("[TB] FAIL zero_plaintext: got %h want 0", plaintext); end
    ciphertext = C1_CT;
    key        = C1_KEY;
    in_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || plaintext !== 128'h0 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: got valid=%b ready=%b pt=%h want valid=1 ready=0 pt=0",
                 i, out_valid, in_ready, plaintext);
      end
    end
    in_valid = 1'b0;
    releaseResult();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    int lat;
    startJob(C1_CT, C1_KEY);
    repeat (12) @(negedge clk);
    ciphertext = B_CT;
    key        = B_KEY;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    waitResult(lat);
    checks++; if (lat !== 7) begin errors++; $display("[TB] FAIL busy_latency: got %0d want 7 after pulse", lat); end
    checks++; if (plaintext !== C1_PT) begin errors++; $display("[TB] FAIL busy_plaintext: got %h want %h", plaintext, C1_PT); end
    releaseResult();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL busy_release: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    startJob(B_CT, B_KEY);
    waitResult(lat);
    checks++; if (lat !== 20) begin errors++; $display("[TB] FAIL b2b_latency: got %0d want 20", lat); end
    checks++; if (plaintext !== B_PT) begin errors++; $display("[TB] FAIL b2b_plaintext: got %h want %h", plaintext, B_PT); end
    releaseResult();
  endtask

  task automatic test_reset_mid_round();
    bit sawValid;
    startJob(C1_CT, C1_KEY);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || plaintext !== 128'h0) begin
      errors++;
      $display("[TB] FAIL abort_state: got ready=%b valid=%b pt=%h want 1/0/0", in_ready, out_valid, plaintext);
    end
    rst = 1'b0;
    sawValid = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checks++; if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_output: got out_valid pulse want none"); end
    test_vector("abort_c1", C1_CT, C1_KEY, C1_PT);
  endtask

  task automatic test_random_loopback();
    logic [127:0] p, k;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      startJob(encModel(p, k), k);
      waitResult(lat);
      checks++; if (lat !== 20) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d want 20", n, lat); end
      checks++; if (plaintext !== p) begin errors++; $display("[TB] FAIL rand%0d_plaintext: got %h want %h", n, plaintext, p); end
      releaseResult();
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    key        = '0;
    buildSbox();
    @(negedge clk);
    test_reset();
    test_vector("c1", C1_CT, C1_KEY, C1_PT);
    test_vector("appb", B_CT, B_KEY, B_PT);
    test_hold();
    test_back_to_back();
    test_reset_mid_round();
    test_random_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_decrypt_seq.md
AES128_DECRYPT_SEQ -- requirements
Module: aes128_decrypt_seq

Interface
REQ-001 Clock and reset: the block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  ciphertext/key offered.
REQ-005 in_ready  output  1  block can accept a job.
REQ-006 ciphertext  input  128  AES block; byte 0 = bits [127:120], column-major state (FIPS-197).
REQ-007 key  input  128  AES-128 cipher key, same byte order.
REQ-008 out_valid  output  1  plaintext valid.
REQ-009 out_ready  input  1  consumer accepts plaintext.
REQ-010 plaintext  output  128  decrypted block, same byte order.

Function
REQ-011 The block SHALL be the inverse of the team's combinational AES-128 ECB encryptor: for any key K and block P, decrypt(encrypt(P,K),K) == P.
REQ-012 States SHALL be IDLE, KEYEXP, ROUND, DONE. A 4-bit round counter SHALL track progress.
REQ-013 IDLE: in_ready=1; on in_valid&&in_ready at edge E0, the block SHALL register ciphertext and key, load the counter with 1 and go to KEYEXP. in_valid while not IDLE SHALL be ignored.
REQ-014 KEYEXP: each cycle SHALL apply one forward key-expansion step (RotWord, SubWord, Rcon = 01,02,04,08,10,20,40,80,1b,36 for steps 1..10). After step 10 the key register SHALL hold rk10, and on that same edge the state register SHALL become ciphertext ^ rk10. The FSM then goes to ROUND with the counter at 9.
REQ-015 Inverse key step: from rk(r+1) = {a,b,c,d}, compute d'=d^c, c'=c^b, b'=b^a, a'=a^SubWord(RotWord(d'))^Rcon(r+1). The result is rk(r) = {a',b',c',d'}.
REQ-016 ROUND, counter r = 9..1: each cycle SHALL set state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk(r)) and key <= rk(r).
REQ-017 ROUND, r = 0: the cycle SHALL set state <= InvSubBytes(InvShiftRows(state)) ^ rk0, with no InvMixColumns, then go to DONE.
REQ-018 Latency: out_valid SHALL rise after edge E20, i.e. 20 cycles after acceptance (10 KEYEXP + 10 ROUND).
REQ-019 DONE: out_valid=1 and plaintext=state, both held stable until out_ready=1. On the out_ready edge the FSM SHALL go to IDLE. in_ready SHALL be 0 in DONE, so there is no same-cycle accept.
REQ-020 Throughput: at most one job per 22 cycles when out_ready is held high.
REQ-021 InvSubBytes SHALL use the full 256-entry FIPS-197 inverse S-box. The forward S-box is also required for the key schedule.
REQ-022 InvMixColumns SHALL use GF(2^8) multiplies by 0e,0b,0d,09 with the polynomial 0x11b.
REQ-023 plaintext SHALL be driven only from the state register: no combinational path from any input to any output.

Reset
REQ-024 rst SHALL force IDLE, in_ready=1, out_valid=0, plaintext=0, counter=0, and clear the key and state registers.
REQ-025 rst asserted in KEYEXP, ROUND or DONE SHALL abort the job, with no out_valid for it. rst has priority over in_valid and out_ready.

Verification
REQ-026 FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, out_valid exactly 20 cycles after accept.
REQ-027 FIPS-197 App. B vector: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
REQ-028 Zero key with ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> plaintext all zeros. Then hold out_ready=0 for 5 cycles -> out_valid and plaintext stay stable and in_ready stays 0.
REQ-029 Backpressure and busy: a second in_valid pulse during ROUND -> ignored, and only the first result appears. After out_ready, in_ready=1 on the next cycle and a back-to-back job is accepted.
REQ-030 Reset mid-ROUND (cycle 15 after accept) -> next cycle in_ready=1, out_valid=0, plaintext=0. A subsequent C.1 job then decrypts correctly.
REQ-031 Random loopback: 1000 random {P,K} pairs through the combinational encryptor into this block -> plaintext == P every time.
